// File: rtl/alu_issue_stage.sv
// Issue register between register read and the execute-stage ALU: decodes one
// MIPS instruction per handshake into ALU operands/control and holds it under valid/ready.
module alu_issue_stage #(
   parameter int DATA_W = 32,
   parameter int CTL_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [CTL_W-1:0]  alu_ctl,
   output logic              alu_sign,
   output logic [4:0]        dst_reg,
   output logic              reg_write,
   output logic              illegal
);

   localparam logic [CTL_W-1:0] CTL_AND = 5'b00000;
   localparam logic [CTL_W-1:0] CTL_OR  = 5'b00001;
   localparam logic [CTL_W-1:0] CTL_ADD = 5'b00010;
   localparam logic [CTL_W-1:0] CTL_SUB = 5'b00110;
   localparam logic [CTL_W-1:0] CTL_SLT = 5'b00111;
   localparam logic [CTL_W-1:0] CTL_NOR = 5'b01100;
   localparam logic [CTL_W-1:0] CTL_XOR = 5'b01101;
   localparam logic [CTL_W-1:0] CTL_SLL = 5'b10000;
   localparam logic [CTL_W-1:0] CTL_SRL = 5'b11000;
   localparam logic [CTL_W-1:0] CTL_SRA = 5'b11001;

   logic [5:0]        op_s, funct_s;
   logic [4:0]        rt_s, rd_s, shamt_s;
   logic [DATA_W-1:0] sext_s, zext_s;

   logic [CTL_W-1:0]  ctl_s;
   logic              sign_s, wr_s, ill_s, load_s;
   logic [DATA_W-1:0] in1_s, in2_s;
   logic [4:0]        dst_s;

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] in1_q, in2_q;
   logic [CTL_W-1:0]  ctl_q;
   logic              sign_q, wr_q, ill_q;
   logic [4:0]        dst_q;

   assign op_s    = instr[31:26];
   assign rt_s    = instr[20:16];
   assign rd_s    = instr[15:11];
   assign shamt_s = instr[10:6];
   assign funct_s = instr[5:0];
   assign sext_s  = {{16{instr[15]}}, instr[15:0]};
   assign zext_s  = {16'h0000, instr[15:0]};

   // Instruction decode into ALU control, operand selection and write-back intent.
   always_comb begin
      ctl_s  = CTL_AND;
      sign_s = 1'b0;
      in1_s  = rs_data;
      in2_s  = rt_data;
      dst_s  = rt_s;
      wr_s   = 1'b0;
      ill_s  = 1'b0;
      case (op_s)
         6'h00: begin
            dst_s = rd_s;
            wr_s  = 1'b1;
            case (funct_s)
               6'h20, 6'h21: ctl_s = CTL_ADD;
               6'h22, 6'h23: ctl_s = CTL_SUB;
               6'h24:        ctl_s = CTL_AND;
               6'h25:        ctl_s = CTL_OR;
               6'h26:        ctl_s = CTL_XOR;
               6'h27:        ctl_s = CTL_NOR;
               6'h2A:        begin ctl_s = CTL_SLT; sign_s = 1'b1; end
               6'h2B:        ctl_s = CTL_SLT;
               6'h00:        begin ctl_s = CTL_SLL; in1_s = {27'd0, shamt_s}; end
               6'h02:        begin ctl_s = CTL_SRL; in1_s = {27'd0, shamt_s}; end
               6'h03:        begin ctl_s = CTL_SRA; in1_s = {27'd0, shamt_s}; end
               6'h04:        ctl_s = CTL_SLL;
               6'h06:        ctl_s = CTL_SRL;
               6'h07:        ctl_s = CTL_SRA;
               6'h08:        begin ctl_s = CTL_ADD; wr_s = 1'b0; end
               6'h09:        ctl_s = CTL_ADD;
               default:      begin ctl_s = CTL_AND; wr_s = 1'b0; ill_s = 1'b1; end
            endcase
         end
         6'h08, 6'h09: begin ctl_s = CTL_ADD; in2_s = sext_s; wr_s = 1'b1; end
         6'h0C:        begin ctl_s = CTL_AND; in2_s = zext_s; wr_s = 1'b1; end
         6'h0D:        begin ctl_s = CTL_OR;  in2_s = zext_s; wr_s = 1'b1; end
         6'h0E:        begin ctl_s = CTL_XOR; in2_s = zext_s; wr_s = 1'b1; end
         6'h0A:        begin ctl_s = CTL_SLT; in2_s = sext_s; sign_s = 1'b1; wr_s = 1'b1; end
         6'h0B:        begin ctl_s = CTL_SLT; in2_s = sext_s; wr_s = 1'b1; end
         6'h0F:        begin ctl_s = CTL_SLL; in1_s = 32'd16; in2_s = zext_s; wr_s = 1'b1; end
         6'h23:        begin ctl_s = CTL_ADD; in2_s = sext_s; wr_s = 1'b1; end
         6'h2B:        begin ctl_s = CTL_ADD; in2_s = sext_s; end
         6'h04, 6'h05: ctl_s = CTL_SUB;
         default:      begin ctl_s = CTL_AND; ill_s = 1'b1; end
      endcase
   end

   assign in_ready = !valid_q || out_ready;
   assign load_s   = in_valid && in_ready && !flush;
   // Flush outranks a load so a squashed cycle never refills the register.
   assign valid_d  = flush ? 1'b0 : (load_s ? 1'b1 : (out_ready ? 1'b0 : valid_q));

   // Issue register: valid bit always updates, payload only on an accepted load.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         in1_q   <= '0;
         in2_q   <= '0;
         ctl_q   <= CTL_AND;
         sign_q  <= 1'b0;
         dst_q   <= 5'd0;
         wr_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (load_s) begin
            in1_q  <= in1_s;
            in2_q  <= in2_s;
            ctl_q  <= ctl_s;
            sign_q <= sign_s;
            dst_q  <= dst_s;
            wr_q   <= wr_s && (dst_s != 5'd0);
            ill_q  <= ill_s;
         end
      end
   end

   assign out_valid = valid_q;
   assign alu_in1   = in1_q;
   assign alu_in2   = in2_q;
   assign alu_ctl   = ctl_q;
   assign alu_sign  = sign_q;
   assign dst_reg   = dst_q;
   assign reg_write = wr_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode vectors, stall,
// back-to-back throughput, flush and reset behaviour.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] instr, rs_data, rt_data, alu_in1, alu_in2;
   logic [4:0]  alu_ctl, dst_reg;
   logic        alu_sign, reg_write, illegal;

   int n_checks = 0;
   int n_pass   = 0;

   alu_issue_stage #(.DATA_W(32), .CTL_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .alu_in1(alu_in1),
      .alu_in2(alu_in2), .alu_ctl(alu_ctl), .alu_sign(alu_sign),
      .dst_reg(dst_reg), .reg_write(reg_write), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single cycle with out_ready high.
   task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
      instr = ins; rs_data = rs; rt_data = rt; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in1", alu_in1, 32'd0);
      check("rst_in2", alu_in2, 32'd0);
      check("rst_ctl", {27'd0, alu_ctl}, 32'd0);
      check("rst_misc", {27'd0, alu_sign, reg_write, illegal, 2'b00}, 32'd0);
      check("rst_dst", {27'd0, dst_reg}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      out_ready = 1'b1;
      issue(32'h00851021, 32'd5, 32'd7);
      check("addu_valid", {31'd0, out_valid}, 32'd1);
      check("addu_ctl", {27'd0, alu_ctl}, 32'h02);
      check("addu_in1", alu_in1, 32'd5);
      check("addu_in2", alu_in2, 32'd7);
      check("addu_dst", {27'd0, dst_reg}, 32'd2);
      check("addu_wr_sign", {30'd0, reg_write, alu_sign}, 32'd2);

      issue(32'h00061903, 32'h0, 32'h80000000);
      check("sra_ctl", {27'd0, alu_ctl}, 32'h19);
      check("sra_in1", alu_in1, 32'd4);
      check("sra_in2", alu_in2, 32'h80000000);
      check("sra_dst", {27'd0, dst_reg}, 32'd3);

      issue(32'h2928FFFF, 32'd1, 32'd0);
      check("slti_in2", alu_in2, 32'hFFFFFFFF);
      check("slti_ctl", {27'd0, alu_ctl}, 32'h07);
      check("slti_sign", {31'd0, alu_sign}, 32'd1);
      check("slti_dst", {27'd0, dst_reg}, 32'd8);

      issue(32'h3128FFFF, 32'd1, 32'd0);
      check("andi_in2", alu_in2, 32'h0000FFFF);
      check("andi_ctl", {27'd0, alu_ctl}, 32'h00);
      check("andi_sign", {31'd0, alu_sign}, 32'd0);

      issue(32'h3C011234, 32'hDEAD, 32'hBEEF);
      check("lui_ctl", {27'd0, alu_ctl}, 32'h10);
      check("lui_in1", alu_in1, 32'd16);
      check("lui_in2", alu_in2, 32'h00001234);
      check("lui_dst", {27'd0, dst_reg}, 32'd1);

      issue(32'h10850003, 32'd9, 32'd11);
      check("beq_ctl", {27'd0, alu_ctl}, 32'h06);
      check("beq_in2", alu_in2, 32'd11);
      check("beq_wr", {31'd0, reg_write}, 32'd0);

      issue(32'hFC000000, 32'd1, 32'd2);
      check("ill_flag", {31'd0, illegal}, 32'd1);
      check("ill_wr", {31'd0, reg_write}, 32'd0);
      check("ill_ctl", {27'd0, alu_ctl}, 32'h00);
      check("ill_valid", {31'd0, out_valid}, 32'd1);

      issue(32'h00850021, 32'd5, 32'd7);
      check("rd0_wr", {31'd0, reg_write}, 32'd0);
      check("rd0_ctl", {27'd0, alu_ctl}, 32'h02);
      check("rd0_ill", {31'd0, illegal}, 32'd0);
      tick();
      check("drain_valid", {31'd0, out_valid}, 32'd0);

      // Stall: entry with rs=100 must hold while inputs churn.
      out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00851021; rs_data = 32'd100; rt_data = 32'd1;
      tick();
      check("stall_load", alu_in1, 32'd100);
      for (int i = 0; i < 3; i++) begin
         rs_data = 32'd900 + i; instr = 32'h3128FFFF;
         tick();
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_in1", alu_in1, 32'd100);
         check("stall_ctl", {27'd0, alu_ctl}, 32'h02);
      end
      out_ready = 1'b1; instr = 32'h00851021;
      for (int k = 1; k <= 4; k++) begin
         rs_data = 32'd100 + k;
         tick();
         check("b2b_valid", {31'd0, out_valid}, 32'd1);
         check("b2b_in1", alu_in1, 32'd100 + k);
      end
      in_valid = 1'b0;
      tick();
      check("b2b_drain", {31'd0, out_valid}, 32'd0);

      // Flush while stalled drops the entry.
      out_ready = 1'b0;
      issue(32'h00851021, 32'd55, 32'd1);
      check("fl_pre_valid", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_stall_valid", {31'd0, out_valid}, 32'd0);

      // Flush together with in_valid loads nothing and leaves in_ready alone.
      flush = 1'b1; in_valid = 1'b1; rs_data = 32'd77;
      #1;
      check("fl_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_noload", {31'd0, out_valid}, 32'd0);

      // Reset in mid-stall clears everything.
      issue(32'h00851021, 32'd66, 32'd3);
      check("rs_pre_valid", {31'd0, out_valid}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rs_mid_valid", {31'd0, out_valid}, 32'd0);
      check("rs_mid_in1", alu_in1, 32'd0);
      check("rs_mid_wr", {31'd0, reg_write}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decoded-operation issue register that drives the execute-stage ALU's operand and control interface (in1, in2, ALUCtl, Sign).
- Accepts one MIPS instruction plus its register-file operands per handshake.
- Decodes the ALU operation, selects and extends the operands, and holds the result in a flushable pipeline register.
- Sits between the register-read stage and the ALU, with valid/ready flow control on both sides.

Parameters:
- DATA_W, 32, operand width; fixed at 32 for the MIPS datapath.
- CTL_W, 5, ALU control code width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  MIPS instruction word.
- rs_data  input  32  value of register rs.
- rt_data  input  32  value of register rt.
- flush  input  1  synchronous squash of the held entry; no load this cycle.
- out_valid  output  1  held entry valid.
- out_ready  input  1  downstream ALU/EX consumes the entry.
- alu_in1  output  32  ALU operand 1; carries the shift amount in [4:0] for shifts.
- alu_in2  output  32  ALU operand 2.
- alu_ctl  output  5  ALU control code.
- alu_sign  output  1  1 = signed compare.
- dst_reg  output  5  destination register number.
- reg_write  output  1  entry writes the register file.
- illegal  output  1  undecodable opcode or funct.

Behaviour:
- Reset: clk and reset are fixed as stated; reset is synchronous and active-high. All registered outputs clear: out_valid=0, alu_in1=0, alu_in2=0, alu_ctl=5'b00000, alu_sign=0, dst_reg=0, reg_write=0, illegal=0.
- in_ready = !out_valid || out_ready. It is combinational and never depends on in_valid.
- Load condition: in_valid && in_ready && !flush. The entry captures on the same edge. Latency is 1 cycle from accept to out_valid=1.
- out_valid next state, in priority order:
  - reset -> 0
  - flush -> 0
  - load -> 1
  - out_ready -> 0
  - otherwise hold.
- Simultaneous load and consume gives back-to-back throughput of 1 per cycle.
- With out_valid=1 and out_ready=0, every output holds stable regardless of instr, rs_data or rt_data.
- alu_ctl codes:
  - AND=00000, OR=00001, ADD=00010, SUB=00110, SLT=00111
  - NOR=01100, XOR=01101, SLL=10000, SRL=11000, SRA=11001
- R-type (op=0x00), by funct:
  - 0x20 and 0x21 -> ADD; 0x22 and 0x23 -> SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
  - 0x2A SLT with sign=1; 0x2B SLT with sign=0.
  - 0x00, 0x02, 0x03 -> SLL/SRL/SRA with in1 = {27'b0, shamt}.
  - 0x04, 0x06, 0x07 -> SLL/SRL/SRA with in1 = rs_data.
  - 0x08 jr -> ADD, reg_write=0.
  - 0x09 jalr -> ADD, reg_write=1.
  - Non-shift R-type: in1 = rs_data. All R-type: in2 = rt_data, dst = rd.
- I-type: in1 = rs_data, dst = rt.
  - 0x08 and 0x09 -> ADD, imm sign-extended.
  - 0x0C, 0x0D, 0x0E -> AND/OR/XOR, imm zero-extended.
  - 0x0A -> SLT with sign=1; 0x0B -> SLT with sign=0. Both sign-extend the imm.
  - 0x0F lui -> SLL with in1 = 32'd16 and in2 = zero-extended imm.
  - 0x23 lw -> ADD, sign-extended imm, reg_write=1.
  - 0x2B sw -> ADD, reg_write=0.
  - 0x04 and 0x05 beq/bne -> SUB with in2 = rt_data, reg_write=0.
- alu_sign is 1 only for signed compares; it is 0 for every other operation.
- Illegal or unlisted opcode/funct: alu_ctl=AND, reg_write=0, illegal=1. The entry still flows so the exception logic can observe it.
- Write to $0: if dst_reg=0 then reg_write is forced to 0.
- Flush while holding a stalled entry: the entry is dropped and out_valid=0 next cycle. A flush asserted together with in_valid loads nothing, and in_ready is unaffected by flush.
- Reset mid-stall clears the entry. No partial state survives reset.

Test Plan:
- Reset then idle: out_valid=0, all outputs 0, in_ready=1.
- Addu: instr=0x00851021, rs=5, rt=7 -> next cycle alu_ctl=00010, in1=5, in2=7, dst=2, reg_write=1, sign=0.
- Sra: instr=0x00061903, rt=0x80000000 -> alu_ctl=11001, in1=4, in2=0x80000000, dst=3.
- Extension:
  - slti instr=0x2928FFFF -> in2=0xFFFFFFFF, alu_ctl=00111, sign=1.
  - andi instr=0x3128FFFF -> in2=0x0000FFFF, alu_ctl=00000.
  - lui instr=0x3C011234 -> alu_ctl=10000, in1=16, in2=0x00001234.
- Stall/throughput: hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 and outputs stable. Then out_ready=1 for 4 cycles -> 4 entries transfer back-to-back with no bubbles.
- Flush and illegal cases:
  - Flush during a stall -> out_valid=0 next cycle.
  - Flush together with in_valid -> no load.
  - Opcode 0x3F -> illegal=1, reg_write=0.
  - addu with rd=0 -> reg_write=0.
